// File: rtl/cnn_region_mem_if.sv
// Host bus, layer handshake and engine RAM port of cnn_region_mem.
// slave = the region memory/sequencer, master = host + layer engines.
interface cnn_region_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int PTR_W  = 12
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              layer_start;
  logic [3:0]        layer_idx;
  logic              layer_done;
  logic              layer_abort;
  logic [PTR_W-1:0]  eng_addr;
  logic              eng_wr;
  logic [DATA_W-1:0] eng_wdata;
  logic [DATA_W-1:0] eng_rdata;
  logic [PTR_W-1:0]  cur_wbase;
  logic [PTR_W-1:0]  cur_wlen;

  modport slave (
    input  chipselect, write, read, address, writedata, layer_done, eng_addr, eng_wr, eng_wdata,
    output readdata, layer_start, layer_idx, layer_abort, eng_rdata, cur_wbase, cur_wlen
  );
  modport master (
    output chipselect, write, read, address, writedata, layer_done, eng_addr, eng_wr, eng_wdata,
    input  readdata, layer_start, layer_idx, layer_abort, eng_rdata, cur_wbase, cur_wlen
  );
endinterface

// File: rtl/cnn_region_mem.sv
// Shared region RAM with host streaming access and a layer start/done sequencer.
// Optional CNN_REGION_MEM_IRQ_EN adds a level irq output for DONE entry / new error.
module cnn_region_mem #(
  parameter int DATA_W      = 16,
  parameter int NUM_REGIONS = 5,
  parameter int MEM_DEPTH   = 4096,
  parameter int ADDR_W      = 6
) (
  input logic clk,
  input logic reset,
  cnn_region_mem_if.slave bus
`ifdef CNN_REGION_MEM_IRQ_EN
  , output logic irq
`endif
);
  localparam int PTR_W = $clog2(MEM_DEPTH);
  localparam int RW    = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [4:0] NR   = 5'(NUM_REGIONS);
  localparam logic [3:0] LAST = 4'(NUM_REGIONS - 2);

  typedef enum logic [1:0] {IDLE, RUN, WAIT, DONE} state_t;
  typedef struct packed {
    logic       wr;
    logic       rd;
    logic [1:0] space;
    logic [3:0] idx;
    logic       vld;
  } host_req_t;

  host_req_t req;
  state_t    state, state_n;

  logic [PTR_W-1:0] base [NUM_REGIONS];
  logic [PTR_W-1:0] len  [NUM_REGIONS];
  logic [PTR_W-1:0] wptr [NUM_REGIONS];
  logic [PTR_W-1:0] rptr [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] loaded;

  logic [RW-1:0]     ri, wsel;
  logic [3:0]        k_q, k_n;
  logic [PTR_W-1:0]  wbase_q, wlen_q;
  logic              abort_q, err, ovf, all_loaded, busy;
  logic              ctrl_wr, go, clr, stat_rd, blocked, go_bad, err_set;
  logic              data_wr, data_rd, ovf_set, cfg_wr;
  logic              rd_ram_q, eng_q_vld;
  logic [DATA_W-1:0] reg_q, ram_q, ram_wdata;
  logic [PTR_W-1:0]  host_addr, ram_addr;
  logic              ram_we, ram_re;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_comb begin
    req.wr    = bus.chipselect & bus.write;
    req.rd    = bus.chipselect & bus.read;
    req.space = bus.address[5:4];
    req.idx   = bus.address[3:0];
    req.vld   = {1'b0, bus.address[3:0]} < NR;
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_ld
    assign loaded[g] = (wptr[g] == len[g]) && (len[g] != '0);
  end

  assign all_loaded = &loaded;
  assign busy       = (state == RUN) || (state == WAIT);
  // Out-of-range regions alias region 0 for lookups but are gated by req.vld.
  assign ri         = req.vld ? req.idx[RW-1:0] : '0;

  assign ctrl_wr = req.wr && (req.space == 2'd3) && (req.idx == 4'd0);
  assign clr     = ctrl_wr && bus.writedata[1];
  assign go      = ctrl_wr && bus.writedata[0] && !bus.writedata[1];
  assign stat_rd = req.rd && (req.space == 2'd3) && (req.idx == 4'd1);
  assign blocked = busy && (req.wr || req.rd) && (req.space != 2'd3);
  assign cfg_wr  = req.wr && !busy && req.vld && ((req.space == 2'd1) || (req.space == 2'd2));
  assign data_wr = req.wr && !busy && req.vld && (req.space == 2'd0) && (wptr[ri] != len[ri]);
  assign ovf_set = req.wr && !busy && req.vld && (req.space == 2'd0) && (wptr[ri] == len[ri]);
  assign data_rd = req.rd && !req.wr && !busy && req.vld && (req.space == 2'd0);
  assign err_set = go_bad || blocked;

  always_comb begin
    state_n = state;
    k_n     = k_q;
    go_bad  = 1'b0;
    if (clr) begin
      state_n = IDLE;
      k_n     = '0;
    end else begin
      case (state)
        IDLE, DONE: if (go) begin
          if (all_loaded) begin
            state_n = RUN;
            k_n     = '0;
          end else begin
            go_bad = 1'b1;
          end
        end
        RUN: state_n = WAIT;
        WAIT: if (bus.layer_done) begin
          if (k_q == LAST) state_n = DONE;
          else begin
            state_n = RUN;
            k_n     = k_q + 4'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Weight region of the layer about to start is region k+1.
  assign wsel = k_n[RW-1:0] + RW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      k_q     <= '0;
      wbase_q <= '0;
      wlen_q  <= '0;
      abort_q <= 1'b0;
      err     <= 1'b0;
      ovf     <= 1'b0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
        base[i] <= '0;
        len[i]  <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      state   <= state_n;
      k_q     <= k_n;
      abort_q <= clr && busy;
      if (state_n == RUN) begin
        wbase_q <= base[wsel];
        wlen_q  <= len[wsel];
      end
      if (clr) begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
          wptr[i] <= '0;
          rptr[i] <= '0;
        end
      end else if (cfg_wr) begin
        if (req.space == 2'd1) base[ri] <= bus.writedata[PTR_W-1:0];
        else                   len[ri]  <= bus.writedata[PTR_W-1:0];
        wptr[ri] <= '0;
        rptr[ri] <= '0;
      end else begin
        if (data_wr) wptr[ri] <= wptr[ri] + PTR_W'(1);
        if (data_rd) rptr[ri] <= (rptr[ri] + PTR_W'(1) == len[ri]) ? '0 : rptr[ri] + PTR_W'(1);
      end
      if (clr) begin
        err <= 1'b0;
        ovf <= 1'b0;
      end else begin
        if (stat_rd) begin
          err <= 1'b0;
          ovf <= 1'b0;
        end
        if (err_set) err <= 1'b1;
        if (ovf_set) ovf <= 1'b1;
      end
    end
  end

  // Readback: RAM words come straight from ram_q, registers from reg_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ram_q  <= 1'b0;
      reg_q     <= '0;
      eng_q_vld <= 1'b0;
    end else begin
      eng_q_vld <= busy;
      if (busy) rd_ram_q <= 1'b0;
      if (req.rd) begin
        rd_ram_q <= data_rd;
        reg_q    <= '0;
        if (!busy && req.vld && (req.space == 2'd1)) reg_q <= DATA_W'(base[ri]);
        if (!busy && req.vld && (req.space == 2'd2)) reg_q <= DATA_W'(len[ri]);
        if (stat_rd) reg_q <= DATA_W'({err, ovf, state == DONE, busy, all_loaded});
      end
    end
  end

  // Single RAM port: engines own it while busy, the host otherwise.
  assign host_addr = base[ri] + (req.wr ? wptr[ri] : rptr[ri]);
  assign ram_addr  = busy ? bus.eng_addr  : host_addr;
  assign ram_we    = busy ? bus.eng_wr    : data_wr;
  assign ram_wdata = busy ? bus.eng_wdata : bus.writedata;
  assign ram_re    = busy || data_rd;

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  assign bus.readdata    = rd_ram_q ? ram_q : reg_q;
  assign bus.eng_rdata   = eng_q_vld ? ram_q : '0;
  assign bus.layer_start = (state == RUN);
  assign bus.layer_idx   = k_q;
  assign bus.layer_abort = abort_q;
  assign bus.cur_wbase   = wbase_q;
  assign bus.cur_wlen    = wlen_q;

`ifdef CNN_REGION_MEM_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else if (((state_n == DONE) && (state != DONE)) || (err_set && !err)) irq <= 1'b1;
    else if (stat_rd || clr) irq <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_cnn_region_mem.sv
// Directed bench for cnn_region_mem: host streaming, overflow, wrap, sequencing, clear, reset.
module tb_cnn_region_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [15:0] d;

  localparam logic [11:0] EB [4] = '{12'h200, 12'hFFE, 12'h400, 12'h300};
  localparam logic [11:0] EL [4] = '{12'd2, 12'd4, 12'd3, 12'd1};

  cnn_region_mem_if #(.DATA_W(16), .ADDR_W(6), .PTR_W(12)) bif ();
`ifdef CNN_REGION_MEM_IRQ_EN
  logic irq;
`endif

  cnn_region_mem #(.DATA_W(16), .NUM_REGIONS(5), .MEM_DEPTH(4096), .ADDR_W(6)) dut (
    .clk(clk), .reset(reset), .bus(bif)
`ifdef CNN_REGION_MEM_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic wr(input logic [5:0] a, input logic [15:0] v);
    @(negedge clk);
    bif.chipselect = 1'b1; bif.write = 1'b1; bif.address = a; bif.writedata = v;
    @(negedge clk);
    bif.chipselect = 1'b0; bif.write = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [15:0] v);
    @(negedge clk);
    bif.chipselect = 1'b1; bif.read = 1'b1; bif.address = a;
    @(negedge clk);
    bif.chipselect = 1'b0; bif.read = 1'b0;
    v = bif.readdata;
  endtask

  task automatic pulse_done();
    @(negedge clk); bif.layer_done = 1'b1;
    @(negedge clk); bif.layer_done = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bif.readdata !== 16'h0) begin failures++; $display("FAIL rst_readdata got=%h exp=0000", bif.readdata); end
    checks++; if (bif.layer_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%b exp=0", bif.layer_start); end
    checks++; if (bif.layer_idx !== 4'd0) begin failures++; $display("FAIL rst_idx got=%h exp=0", bif.layer_idx); end
    checks++; if (bif.layer_abort !== 1'b0) begin failures++; $display("FAIL rst_abort got=%b exp=0", bif.layer_abort); end
    checks++; if (bif.cur_wbase !== 12'h0 || bif.cur_wlen !== 12'h0) begin failures++; $display("FAIL rst_cur got=%h/%h exp=0/0", bif.cur_wbase, bif.cur_wlen); end
    checks++; if (bif.eng_rdata !== 16'h0) begin failures++; $display("FAIL rst_eng_rdata got=%h exp=0000", bif.eng_rdata); end
    rd(6'h31, d);
    checks++; if (d !== 16'h0) begin failures++; $display("FAIL rst_status got=%h exp=0000", d); end
  endtask

  task automatic test_data_ovf();
    wr(6'h10, 16'h0100); wr(6'h20, 16'd4);
    for (int i = 1; i <= 5; i++) wr(6'h00, 16'(i));
    rd(6'h31, d);
    checks++; if (d !== 16'h0008) begin failures++; $display("FAIL ovf_status got=%h exp=0008", d); end
    rd(6'h31, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL ovf_cleared got=%h exp=0000", d); end
    rd(6'h10, d);
    checks++; if (d !== 16'h0100) begin failures++; $display("FAIL base0_read got=%h exp=0100", d); end
    for (int i = 0; i < 5; i++) begin
      rd(6'h00, d);
      checks++; if (d !== 16'((i % 4) + 1)) begin failures++; $display("FAIL data0_read%0d got=%h exp=%h", i, d, 16'((i % 4) + 1)); end
    end
  endtask

  task automatic test_wrap();
    wr(6'h12, 16'h0FFE); wr(6'h22, 16'd4);
    for (int i = 0; i < 4; i++) wr(6'h02, 16'hA + 16'(i));
    wr(6'h13, 16'h0000); wr(6'h23, 16'd2);
    wr(6'h14, 16'h0FFE); wr(6'h24, 16'd2);
    rd(6'h03, d);
    checks++; if (d !== 16'h000C) begin failures++; $display("FAIL wrap_mem000 got=%h exp=000c", d); end
    rd(6'h03, d);
    checks++; if (d !== 16'h000D) begin failures++; $display("FAIL wrap_mem001 got=%h exp=000d", d); end
    rd(6'h04, d);
    checks++; if (d !== 16'h000A) begin failures++; $display("FAIL wrap_memffe got=%h exp=000a", d); end
    rd(6'h04, d);
    checks++; if (d !== 16'h000B) begin failures++; $display("FAIL wrap_memfff got=%h exp=000b", d); end
    wr(6'h25, 16'd7);
    rd(6'h25, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL bad_region_len got=%h exp=0000", d); end
  endtask

  task automatic test_go_err();
    wr(6'h11, 16'h0200); wr(6'h21, 16'd2); wr(6'h01, 16'h0011); wr(6'h01, 16'h0012);
    wr(6'h14, 16'h0300); wr(6'h24, 16'd1); wr(6'h04, 16'h0041);
    wr(6'h23, 16'd0);
    wr(6'h30, 16'h0001);
    checks++; if (bif.layer_start !== 1'b0) begin failures++; $display("FAIL goerr_start got=%b exp=0", bif.layer_start); end
`ifdef CNN_REGION_MEM_IRQ_EN
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL goerr_irq got=%b exp=1", irq); end
`endif
    rd(6'h31, d);
    checks++; if (d !== 16'h0010) begin failures++; $display("FAIL goerr_status got=%h exp=0010", d); end
`ifdef CNN_REGION_MEM_IRQ_EN
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL goerr_irq_clr got=%b exp=0", irq); end
`endif
    rd(6'h31, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL goerr_cleared got=%h exp=0000", d); end
  endtask

  task automatic test_sequence();
    wr(6'h13, 16'h0400); wr(6'h23, 16'd3);
    for (int i = 0; i < 3; i++) wr(6'h03, 16'h31 + 16'(i));
    rd(6'h31, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL seq_loaded got=%h exp=0001", d); end
    wr(6'h30, 16'h0001);
    checks++; if (bif.layer_start !== 1'b1 || bif.layer_idx !== 4'd0) begin failures++; $display("FAIL seq_start0 got=%b/%h exp=1/0", bif.layer_start, bif.layer_idx); end
    checks++; if (bif.cur_wbase !== EB[0] || bif.cur_wlen !== EL[0]) begin failures++; $display("FAIL seq_cur0 got=%h/%h exp=%h/%h", bif.cur_wbase, bif.cur_wlen, EB[0], EL[0]); end
    @(negedge clk);
    checks++; if (bif.layer_start !== 1'b0) begin failures++; $display("FAIL seq_start0_len got=%b exp=0", bif.layer_start); end
    bif.eng_addr = 12'h101;
    @(negedge clk);
    checks++; if (bif.eng_rdata !== 16'h0002) begin failures++; $display("FAIL eng_read got=%h exp=0002", bif.eng_rdata); end
    bif.eng_addr = 12'h500; bif.eng_wdata = 16'h0077; bif.eng_wr = 1'b1;
    @(negedge clk); bif.eng_wr = 1'b0;
    @(negedge clk);
    checks++; if (bif.eng_rdata !== 16'h0077) begin failures++; $display("FAIL eng_write got=%h exp=0077", bif.eng_rdata); end
    rd(6'h31, d);
    checks++; if (d !== 16'h0003) begin failures++; $display("FAIL seq_busy got=%h exp=0003", d); end
    rd(6'h00, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL busy_data_rd got=%h exp=0000", d); end
`ifdef CNN_REGION_MEM_IRQ_EN
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL busy_irq got=%b exp=1", irq); end
`endif
    rd(6'h31, d);
    checks++; if (d !== 16'h0013) begin failures++; $display("FAIL busy_err got=%h exp=0013", d); end
    for (int k = 0; k < 4; k++) begin
      pulse_done();
      if (k < 3) begin
        checks++; if (bif.layer_start !== 1'b1 || bif.layer_idx !== 4'(k + 1)) begin failures++; $display("FAIL seq_start%0d got=%b/%h exp=1/%0d", k + 1, bif.layer_start, bif.layer_idx, k + 1); end
        checks++; if (bif.cur_wbase !== EB[k+1] || bif.cur_wlen !== EL[k+1]) begin failures++; $display("FAIL seq_cur%0d got=%h/%h exp=%h/%h", k + 1, bif.cur_wbase, bif.cur_wlen, EB[k+1], EL[k+1]); end
        @(negedge clk);
        checks++; if (bif.layer_start !== 1'b0) begin failures++; $display("FAIL seq_pulse%0d got=%b exp=0", k + 1, bif.layer_start); end
      end else begin
        checks++; if (bif.layer_start !== 1'b0) begin failures++; $display("FAIL seq_last got=%b exp=0", bif.layer_start); end
      end
    end
`ifdef CNN_REGION_MEM_IRQ_EN
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL done_irq got=%b exp=1", irq); end
`endif
    rd(6'h31, d);
    checks++; if (d !== 16'h0005) begin failures++; $display("FAIL seq_done got=%h exp=0005", d); end
`ifdef CNN_REGION_MEM_IRQ_EN
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL done_irq_clr got=%b exp=0", irq); end
`endif
    pulse_done();
    checks++; if (bif.layer_start !== 1'b0) begin failures++; $display("FAIL done_ignored got=%b exp=0", bif.layer_start); end
    @(negedge clk); bif.eng_addr = 12'h101; bif.eng_wdata = 16'hDEAD; bif.eng_wr = 1'b1;
    @(negedge clk); bif.eng_wr = 1'b0;
    rd(6'h00, d);
    checks++; if (d !== 16'h0002) begin failures++; $display("FAIL idle_eng_wr got=%h exp=0002", d); end
  endtask

  task automatic test_rerun_clear();
    wr(6'h30, 16'h0001);
    checks++; if (bif.layer_start !== 1'b1 || bif.layer_idx !== 4'd0) begin failures++; $display("FAIL rerun_start got=%b/%h exp=1/0", bif.layer_start, bif.layer_idx); end
    @(negedge clk);
    pulse_done();
    @(negedge clk);
    pulse_done();
    @(negedge clk);
    checks++; if (bif.layer_idx !== 4'd2) begin failures++; $display("FAIL rerun_idx2 got=%h exp=2", bif.layer_idx); end
    wr(6'h30, 16'h0002);
    checks++; if (bif.layer_abort !== 1'b1 || bif.layer_idx !== 4'd0) begin failures++; $display("FAIL clr_abort got=%b/%h exp=1/0", bif.layer_abort, bif.layer_idx); end
    @(negedge clk);
    checks++; if (bif.layer_abort !== 1'b0) begin failures++; $display("FAIL clr_abort_len got=%b exp=0", bif.layer_abort); end
    rd(6'h31, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL clr_status got=%h exp=0000", d); end
    rd(6'h00, d);
    checks++; if (d !== 16'h0001) begin failures++; $display("FAIL clr_rptr got=%h exp=0001", d); end
    wr(6'h30, 16'h0003);
    rd(6'h31, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL clr_wins got=%h exp=0000", d); end
  endtask

  task automatic test_reset_mid_wait();
    wr(6'h13, 16'h0040);
    for (int r = 0; r < 5; r++) begin
      wr(6'h20 + 6'(r), 16'd1);
      wr(6'h00 + 6'(r), 16'h50 + 16'(r));
    end
    wr(6'h30, 16'h0001);
    @(negedge clk);
    pulse_done();
    @(negedge clk);
    pulse_done();
    checks++; if (bif.layer_idx !== 4'd2 || bif.cur_wbase !== 12'h040) begin failures++; $display("FAIL rmw_pre got=%h/%h exp=2/040", bif.layer_idx, bif.cur_wbase); end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (bif.layer_idx !== 4'd0 || bif.layer_start !== 1'b0 || bif.layer_abort !== 1'b0) begin failures++; $display("FAIL rmw_ctl got=%h/%b/%b exp=0/0/0", bif.layer_idx, bif.layer_start, bif.layer_abort); end
    checks++; if (bif.cur_wbase !== 12'h0 || bif.cur_wlen !== 12'h0 || bif.readdata !== 16'h0 || bif.eng_rdata !== 16'h0) begin failures++; $display("FAIL rmw_data got=%h/%h/%h/%h exp=0/0/0/0", bif.cur_wbase, bif.cur_wlen, bif.readdata, bif.eng_rdata); end
    @(negedge clk); reset = 1'b0;
    rd(6'h31, d);
    checks++; if (d !== 16'h0000) begin failures++; $display("FAIL rmw_status got=%h exp=0000", d); end
  endtask

  initial begin
    bif.chipselect = 1'b0; bif.write = 1'b0; bif.read = 1'b0; bif.address = '0; bif.writedata = '0;
    bif.layer_done = 1'b0; bif.eng_addr = '0; bif.eng_wr = 1'b0; bif.eng_wdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_data_ovf();
    test_wrap();
    test_go_err();
    test_sequence();
    test_rerun_clear();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
